// File: rtl/firebird7_in_gate1_tessent_data_mux_ctrl_pkg.sv
// Shared types and constants for the firebird7_in gate1 IJTAG data mux controller.
package firebird7_in_gate1_tessent_data_mux_ctrl_pkg;

    // Mux data path width; the select request sits just above the data bits.
    localparam int DATA_WIDTH     = 19;
    localparam int REQ_BIT        = DATA_WIDTH;
    localparam int SETTLE_DEFAULT = 4;

    // Settle sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETUP   = 2'd1,
        ST_ACTIVE  = 2'd2,
        ST_RELEASE = 2'd3
    } state_e;

    // Counter width able to hold the settle count.
    function automatic int cnt_width(input int settle);
        return $clog2(settle + 1);
    endfunction

endpackage

// File: rtl/firebird7_in_gate1_tessent_tdr_shadow.sv
// Capture/shift/update register pair of the mux-control TDR.
// sr[WIDTH] carries the select request, sr[WIDTH-1:0] the override data.
module firebird7_in_gate1_tessent_tdr_shadow
    import firebird7_in_gate1_tessent_data_mux_ctrl_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sel,
    input  logic             ce,
    input  logic             se,
    input  logic             ue,
    input  logic             si,
    input  logic             cap_req,
    input  logic [WIDTH-1:0] cap_data,
    output logic             so,
    output logic [WIDTH-1:0] shadow_data,
    output logic             req
);

    logic [WIDTH:0]   sr_r;
    logic [WIDTH-1:0] shadow_r;
    logic             req_r;

    // Shift register and shadow; update always commits the pre-edge shift value.
    always_ff @(posedge clk) begin
        if (rst) begin
            sr_r     <= {(WIDTH+1){1'b0}};
            shadow_r <= {WIDTH{1'b0}};
            req_r    <= 1'b0;
        end else if (sel) begin
            if (ce) begin
                sr_r <= {cap_req, cap_data};
            end else if (se) begin
                sr_r <= {si, sr_r[WIDTH:1]};
            end else begin
                sr_r <= sr_r;
            end
            if (ue) begin
                shadow_r <= sr_r[WIDTH-1:0];
                req_r    <= sr_r[WIDTH];
            end else begin
                shadow_r <= shadow_r;
                req_r    <= req_r;
            end
        end else begin
            sr_r     <= sr_r;
            shadow_r <= shadow_r;
            req_r    <= req_r;
        end
    end

    assign so          = sr_r[0];
    assign shadow_data = shadow_r;
    assign req         = req_r;

endmodule

// File: rtl/firebird7_in_gate1_tessent_data_mux_ctrl_w19.sv
// IJTAG TDR controller for the gate1 19-bit data mux: the shadow holds the
// override data and select request, and a settle sequencer only asserts or
// releases the mux select after the data has been stable for SETTLE_CYCLES.
module firebird7_in_gate1_tessent_data_mux_ctrl_w19
    import firebird7_in_gate1_tessent_data_mux_ctrl_pkg::*;
#(
    parameter int WIDTH         = DATA_WIDTH,
    parameter int SETTLE_CYCLES = SETTLE_DEFAULT
) (
    input  logic             ijtag_tck,
    input  logic             ijtag_reset,
    input  logic             ijtag_sel,
    input  logic             ijtag_ce,
    input  logic             ijtag_se,
    input  logic             ijtag_ue,
    input  logic             ijtag_si,
    output logic             ijtag_so,
    input  logic [WIDTH-1:0] functional_data_in,
    output logic [WIDTH-1:0] ijtag_data_out,
    output logic             ijtag_select,
    output logic             busy
);

    localparam int              CNT_W    = cnt_width(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [WIDTH-1:0] shadow_data_s;
    logic             req_s;
    state_e           state_r;
    state_e           state_next_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_next_s;
    logic             select_r;
    logic             busy_r;
    logic [WIDTH-1:0] data_out_r;

    firebird7_in_gate1_tessent_tdr_shadow #(
        .WIDTH (WIDTH)
    ) u_tdr (
        .clk         (ijtag_tck),
        .rst         (ijtag_reset),
        .sel         (ijtag_sel),
        .ce          (ijtag_ce),
        .se          (ijtag_se),
        .ue          (ijtag_ue),
        .si          (ijtag_si),
        .cap_req     (select_r),
        .cap_data    (functional_data_in),
        .so          (ijtag_so),
        .shadow_data (shadow_data_s),
        .req         (req_s)
    );

    // Next-state and settle-counter logic of the select sequencer.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (req_s) begin
                    state_next_s = ST_SETUP;
                    cnt_next_s   = CNT_LOAD;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_SETUP: begin
                // A dropped request aborts before select is ever asserted.
                if (!req_s) begin
                    state_next_s = ST_IDLE;
                end else if (cnt_r == CNT_ZERO) begin
                    state_next_s = ST_ACTIVE;
                end else begin
                    cnt_next_s = cnt_r - CNT_ONE;
                end
            end
            ST_ACTIVE: begin
                if (!req_s) begin
                    state_next_s = ST_RELEASE;
                    cnt_next_s   = CNT_LOAD;
                end else begin
                    state_next_s = ST_ACTIVE;
                end
            end
            ST_RELEASE: begin
                // Release always completes so the mux sees a full settle window.
                if (cnt_r == CNT_ZERO) begin
                    if (req_s) begin
                        state_next_s = ST_SETUP;
                        cnt_next_s   = CNT_LOAD;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end else begin
                    cnt_next_s = cnt_r - CNT_ONE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
                cnt_next_s   = CNT_ZERO;
            end
        endcase
    end

    // State, counter and registered output decodes (decoded from next state so
    // select and busy change in the same cycle as the state without glitches).
    always_ff @(posedge ijtag_tck) begin
        if (ijtag_reset) begin
            state_r    <= ST_IDLE;
            cnt_r      <= CNT_ZERO;
            select_r   <= 1'b0;
            busy_r     <= 1'b0;
            data_out_r <= {WIDTH{1'b0}};
        end else begin
            state_r    <= state_next_s;
            cnt_r      <= cnt_next_s;
            select_r   <= (state_next_s == ST_ACTIVE);
            busy_r     <= (state_next_s == ST_SETUP) || (state_next_s == ST_RELEASE);
            data_out_r <= shadow_data_s;
        end
    end

    assign ijtag_select   = select_r;
    assign busy           = busy_r;
    assign ijtag_data_out = data_out_r;

endmodule

// File: tb/tb_firebird7_in_gate1_tessent_data_mux_ctrl_w19.sv
// Directed self-checking bench for the gate1 IJTAG data mux controller.
module tb_firebird7_in_gate1_tessent_data_mux_ctrl_w19;

    logic        ijtag_tck = 1'b0;
    logic        ijtag_reset = 1'b0;
    logic        ijtag_sel = 1'b0;
    logic        ijtag_ce = 1'b0;
    logic        ijtag_se = 1'b0;
    logic        ijtag_ue = 1'b0;
    logic        ijtag_si = 1'b0;
    logic        ijtag_so;
    logic [18:0] functional_data_in = 19'h00000;
    logic [18:0] ijtag_data_out;
    logic        ijtag_select;
    logic        busy;

    int checks = 0;
    int errors = 0;

    firebird7_in_gate1_tessent_data_mux_ctrl_w19 #(
        .WIDTH         (19),
        .SETTLE_CYCLES (4)
    ) dut (
        .ijtag_tck          (ijtag_tck),
        .ijtag_reset        (ijtag_reset),
        .ijtag_sel          (ijtag_sel),
        .ijtag_ce           (ijtag_ce),
        .ijtag_se           (ijtag_se),
        .ijtag_ue           (ijtag_ue),
        .ijtag_si           (ijtag_si),
        .ijtag_so           (ijtag_so),
        .functional_data_in (functional_data_in),
        .ijtag_data_out     (ijtag_data_out),
        .ijtag_select       (ijtag_select),
        .busy               (busy)
    );

    always #5 ijtag_tck = ~ijtag_tck;

    // One rising edge, then settle 1 time unit before sampling or driving.
    task automatic tick();
        @(posedge ijtag_tck);
        #1;
    endtask

    // Shift a 20-bit {req, data} word in, LSB first.
    task automatic shift_word(input logic [19:0] vec);
        ijtag_sel = 1'b1;
        ijtag_se  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            ijtag_si = vec[i];
            tick();
        end
        ijtag_se = 1'b0;
        ijtag_si = 1'b0;
    endtask

    task automatic do_update();
        ijtag_sel = 1'b1;
        ijtag_ue  = 1'b1;
        tick();
        ijtag_ue  = 1'b0;
    endtask

    task automatic test_reset();
        ijtag_reset = 1'b1;
        ijtag_sel = 1'b1; ijtag_ce = 1'b1; ijtag_se = 1'b1; ijtag_ue = 1'b1; ijtag_si = 1'b1;
        tick();
        ijtag_reset = 1'b0;
        ijtag_ce = 1'b0; ijtag_se = 1'b0; ijtag_ue = 1'b0; ijtag_si = 1'b0;
        checks++; if (ijtag_so !== 1'b0) begin errors++; $display("FAIL reset_so: got %b expected 0", ijtag_so); end
        checks++; if (ijtag_select !== 1'b0) begin errors++; $display("FAIL reset_select: got %b expected 0", ijtag_select); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (ijtag_data_out !== 19'h00000) begin errors++; $display("FAIL reset_data: got %h expected 00000", ijtag_data_out); end
    endtask

    task automatic test_setup_and_activate();
        shift_word({1'b1, 19'h5A5A5});
        do_update();   // edge t
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL setup_busy_t: got %b expected 0", busy); end
        for (int k = 1; k <= 4; k++) begin
            tick();
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL setup_busy t+%0d: got %b expected 1", k, busy); end
            checks++; if (ijtag_select !== 1'b0) begin errors++; $display("FAIL setup_select t+%0d: got %b expected 0", k, ijtag_select); end
            checks++; if (ijtag_data_out !== 19'h5A5A5) begin errors++; $display("FAIL setup_data t+%0d: got %h expected 5a5a5", k, ijtag_data_out); end
        end
        tick();        // t+5
        checks++; if (ijtag_select !== 1'b1) begin errors++; $display("FAIL active_select t+5: got %b expected 1", ijtag_select); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL active_busy t+5: got %b expected 0", busy); end
    endtask

    task automatic test_release_and_capture();
        logic [19:0] exp;
        shift_word({1'b0, 19'h0AAAA});
        do_update();   // edge t
        for (int k = 1; k <= 4; k++) begin
            tick();
            checks++; if (ijtag_select !== 1'b0) begin errors++; $display("FAIL release_select t+%0d: got %b expected 0", k, ijtag_select); end
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL release_busy t+%0d: got %b expected 1", k, busy); end
        end
        checks++; if (ijtag_data_out !== 19'h0AAAA) begin errors++; $display("FAIL release_data: got %h expected 0aaaa", ijtag_data_out); end
        tick();        // t+5: IDLE
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL release_idle_busy: got %b expected 0", busy); end
        functional_data_in = 19'h12345;
        ijtag_ce = 1'b1;
        tick();
        ijtag_ce = 1'b0;
        exp = {1'b0, 19'h12345};
        for (int i = 0; i < 20; i++) begin
            checks++; if (ijtag_so !== exp[i]) begin errors++; $display("FAIL capture_status bit %0d: got %b expected %b", i, ijtag_so, exp[i]); end
            ijtag_se = 1'b1;
            tick();
        end
        ijtag_se = 1'b0;
    endtask

    task automatic test_abort_in_setup();
        shift_word({1'b1, 19'h3C3C3});
        do_update();   // edge t: req=1
        // edge t+1: repeated update with shift; commits pre-edge sr (req stays 1)
        ijtag_ue = 1'b1; ijtag_se = 1'b1; ijtag_si = 1'b0;
        tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_busy t+1: got %b expected 1", busy); end
        // edge t+2: update commits shifted word, req=0
        ijtag_se = 1'b0;
        tick();
        ijtag_ue = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_busy t+2: got %b expected 1", busy); end
        checks++; if (ijtag_data_out !== 19'h3C3C3) begin errors++; $display("FAIL abort_preedge_data: got %h expected 3c3c3", ijtag_data_out); end
        tick();        // t+3
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy t+3: got %b expected 0", busy); end
        checks++; if (ijtag_data_out !== 19'h5E1E1) begin errors++; $display("FAIL abort_shift_data: got %h expected 5e1e1", ijtag_data_out); end
        for (int k = 3; k <= 8; k++) begin
            checks++; if (ijtag_select !== 1'b0) begin errors++; $display("FAIL abort_select t+%0d: got %b expected 0", k, ijtag_select); end
            tick();
        end
    endtask

    task automatic test_rerequest_in_release();
        shift_word({1'b1, 19'h00F0F});
        do_update();
        for (int k = 1; k <= 5; k++) tick();
        checks++; if (ijtag_select !== 1'b1) begin errors++; $display("FAIL rereq_pre_active: got %b expected 1", ijtag_select); end
        shift_word({1'b0, 19'h00000});
        do_update();   // edge t: req=0
        ijtag_se = 1'b1; ijtag_si = 1'b1;
        tick();        // t+1: RELEASE starts, sr[19] becomes 1
        ijtag_se = 1'b0; ijtag_si = 1'b0;
        checks++; if (ijtag_select !== 1'b0) begin errors++; $display("FAIL rereq_select t+1: got %b expected 0", ijtag_select); end
        ijtag_ue = 1'b1;
        tick();        // t+2: req=1 inside RELEASE
        ijtag_ue = 1'b0;
        for (int k = 2; k <= 8; k++) begin
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rereq_busy t+%0d: got %b expected 1", k, busy); end
            checks++; if (ijtag_select !== 1'b0) begin errors++; $display("FAIL rereq_select t+%0d: got %b expected 0", k, ijtag_select); end
            tick();
        end
        // t+9
        checks++; if (ijtag_select !== 1'b1) begin errors++; $display("FAIL rereq_select t+9: got %b expected 1", ijtag_select); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rereq_busy t+9: got %b expected 0", busy); end
    endtask

    task automatic test_sel_gating_and_capture_priority();
        logic [19:0] exp;
        shift_word({1'b1, 19'h7FFFF});
        ijtag_sel = 1'b0; ijtag_ue = 1'b1; ijtag_se = 1'b1; ijtag_si = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (ijtag_data_out !== 19'h00000) begin errors++; $display("FAIL selgate_data %0d: got %h expected 00000", k, ijtag_data_out); end
            checks++; if (ijtag_so !== 1'b1) begin errors++; $display("FAIL selgate_so %0d: got %b expected 1", k, ijtag_so); end
            checks++; if (ijtag_select !== 1'b1) begin errors++; $display("FAIL selgate_select %0d: got %b expected 1", k, ijtag_select); end
        end
        ijtag_ue = 1'b0; ijtag_se = 1'b0;
        functional_data_in = 19'h12344;
        ijtag_sel = 1'b1; ijtag_ce = 1'b1; ijtag_se = 1'b1;
        tick();
        ijtag_ce = 1'b0;
        exp = {1'b1, 19'h12344};
        for (int i = 0; i < 20; i++) begin
            checks++; if (ijtag_so !== exp[i]) begin errors++; $display("FAIL prio_capture bit %0d: got %b expected %b", i, ijtag_so, exp[i]); end
            tick();
        end
        ijtag_se = 1'b0;
    endtask

    task automatic test_reset_mid_active();
        shift_word({1'b1, 19'h6B6B6});
        do_update();
        tick();
        checks++; if (ijtag_data_out !== 19'h6B6B6) begin errors++; $display("FAIL midrst_pre_data: got %h expected 6b6b6", ijtag_data_out); end
        checks++; if (ijtag_select !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL midrst_norestart: got select=%b busy=%b expected select=1 busy=0", ijtag_select, busy); end
        ijtag_reset = 1'b1;
        tick();
        ijtag_reset = 1'b0;
        checks++; if (ijtag_select !== 1'b0) begin errors++; $display("FAIL midrst_select: got %b expected 0", ijtag_select); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        checks++; if (ijtag_data_out !== 19'h00000) begin errors++; $display("FAIL midrst_data: got %h expected 00000", ijtag_data_out); end
        checks++; if (ijtag_so !== 1'b0) begin errors++; $display("FAIL midrst_so: got %b expected 0", ijtag_so); end
        tick();
        checks++; if (busy !== 1'b0 || ijtag_select !== 1'b0) begin errors++; $display("FAIL midrst_no_release: got busy=%b select=%b expected 0 0", busy, ijtag_select); end
    endtask

    initial begin
        tick();
        test_reset();
        test_setup_and_activate();
        test_release_and_capture();
        test_abort_in_setup();
        test_rerequest_in_release();
        test_sel_gating_and_capture_priority();
        test_reset_mid_active();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/firebird7_in_gate1_tessent_data_mux_ctrl_w19.md
Name: firebird7_in_gate1_tessent_data_mux_ctrl_w19

Overview:
IJTAG test-data-register controller that drives the select and override data of a 19-bit IJTAG data mux in the firebird7_in gate1 instrument.
- Shifts in override data and a select request; the update operation commits both to a shadow.
- A settle sequencer then asserts or releases the mux select only after the override data has been stable for a programmable number of cycles.
- Capture observes the mux's functional data and the controller status.

Parameters:
WIDTH, 19, width of the mux data path (functional and override data).
SETTLE_CYCLES, 4, cycles data must be stable before select asserts and after it drops; legal range 1..255.

Ports:
ijtag_tck  input  1  test clock; all logic on its rising edge.
ijtag_reset  input  1  synchronous, active-high reset.
ijtag_sel  input  1  TDR selected on the IJTAG network.
ijtag_ce  input  1  capture enable.
ijtag_se  input  1  shift enable.
ijtag_ue  input  1  update enable.
ijtag_si  input  1  scan in.
ijtag_so  output  1  scan out = sr[0].
functional_data_in  input  WIDTH  functional side of the mux, captured for observation.
ijtag_data_out  output  WIDTH  override data to the mux ijtag_data_in.
ijtag_select  output  1  mux select; 1 = override data drives data_out.
busy  output  1  sequencer in SETUP or RELEASE.

Behaviour:
- Reset (synchronous, active-high) clears all state:
  - sr, shadow_data and req go to 0; state goes to IDLE; the settle counter goes to 0.
  - All outputs read 0 the cycle after reset is sampled.
  - A reset mid-sequence drops ijtag_select in the next cycle, with no RELEASE phase.
- Shift register sr is WIDTH+1 bits: bit WIDTH is the select request, bits WIDTH-1:0 are the data.
- Register operations act only while ijtag_sel=1; with ijtag_sel=0, sr and the shadow hold.
  - Capture (ce=1): sr[WIDTH] <= ijtag_select; sr[WIDTH-1:0] <= functional_data_in.
  - Shift (se=1, ce=0): sr <= {ijtag_si, sr[WIDTH:1]}. LSB exits first on ijtag_so.
  - ce=1 and se=1 together: capture wins.
  - Update (ue=1): shadow_data <= sr[WIDTH-1:0]; req <= sr[WIDTH]. Update uses the pre-edge sr, so a simultaneous shift does not affect the committed value.
- ijtag_data_out is registered shadow_data in every state and follows the shadow 1 cycle after update. Data changes while ACTIVE are permitted.
- FSM states: IDLE, SETUP, ACTIVE, RELEASE.
  - IDLE: select=0. If req=1, load the counter with SETTLE_CYCLES-1 and go to SETUP.
  - SETUP: select=0, busy=1. If req=0, go to IDLE (abort; select never asserts). When the counter reaches 0, go to ACTIVE; otherwise decrement.
  - ACTIVE: select=1. If req=0, load the counter and go to RELEASE; select is 0 from the first RELEASE cycle.
  - RELEASE: select=0, busy=1. Always runs to completion, ignoring req. When the counter reaches 0, go to IDLE, or straight to SETUP (counter reloaded) if req=1.
- Latency: for an update edge at cycle t with req 0->1, SETUP starts at t+1 and ijtag_select=1 from t+1+SETTLE_CYCLES. Release is symmetric: IDLE is reached SETTLE_CYCLES cycles after select drops.
- Repeated updates with an unchanged req do not restart the sequencer.
- ijtag_select and busy are registered, glitch-free state decodes.

Decomposition:
- Shared package firebird7_in_gate1_tessent_data_mux_ctrl_pkg holds:
  - the state enum type (IDLE/SETUP/ACTIVE/RELEASE);
  - the localparam for the request bit index;
  - the counter width function $clog2(SETTLE_CYCLES+1).
- One natural sub-module: firebird7_in_gate1_tessent_tdr_shadow, holding the capture/shift/update register pair. The FSM and counter stay in the top level.

Test Plan:
All scenarios use WIDTH=19, SETTLE_CYCLES=4.
- Reset with all enables high -> cycle after reset: ijtag_so=0, ijtag_select=0, busy=0, ijtag_data_out=0.
- Shift 20 bits {req=1, data=19'h5A5A5}, then update at cycle t -> ijtag_data_out=19'h5A5A5 at t+1; busy=1 for t+1..t+4; ijtag_select=1 from t+5.
- From ACTIVE, update with req=0 -> ijtag_select=0 at t+1; busy=1 for 4 cycles; IDLE at t+5. Capture then shifts out status bit 0 plus functional_data_in=19'h12345, LSB first.
- Update req=1, then update req=0 two cycles later (during SETUP) -> ijtag_select never asserts; busy=0 the cycle after the second update.
- Update req=0 then req=1 inside RELEASE -> RELEASE completes its 4 cycles; SETUP runs 4 more; select reasserts 8 cycles after the release started.
- Update with ijtag_sel=0 -> shadow and ijtag_data_out unchanged. ce=se=1 together -> capture value appears on ijtag_so.
